// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, memory width codes, LSU states and alignment helpers
// shared by riscv_lsu and lsu_extract.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [3:0] W_NONE = 4'd0;
    localparam logic [3:0] W_B    = 4'd1;
    localparam logic [3:0] W_H    = 4'd2;
    localparam logic [3:0] W_W    = 4'd4;

    localparam logic [31:0] ERROR_RDATA = 32'h0;

    typedef enum logic [2:0] {IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP} state_t;

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        return (funct3[1:0] == 2'd1 && offset[0]) || (funct3 == F3_W && offset != 2'd0);
    endfunction

    // Accesses that straddle a word boundary and therefore need a second read.
    function automatic logic needs_split(input logic [2:0] funct3, input logic [1:0] offset);
        return (funct3 == F3_W && offset != 2'd0) || (funct3[1:0] == 2'd1 && offset == 2'd3);
    endfunction

endpackage

// File: rtl/lsu_extract.sv
// lsu_extract: picks the addressed byte/halfword/word out of the {hi,lo} read
// window and sign- or zero-extends it according to funct3.
module lsu_extract
    import lsu_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [31:0] word;

    assign word   = 32'({hi, lo} >> {offset, 3'b000});
    assign result = funct3 == F3_B  ? {{24{word[7]}}, word[7:0]} :
                    funct3 == F3_BU ? {24'h0, word[7:0]} :
                    funct3 == F3_H  ? {{16{word[15]}}, word[15:0]} :
                    funct3 == F3_HU ? {16'h0, word[15:0]} : word;
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding load/store unit driving a synchronous-read data memory.
// Define LSU_MISALIGNED_EN to split misaligned loads into two aligned word reads.
module riscv_lsu
    import lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_width,
    output logic        mem_write,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in
);
    state_t      state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] lo_in;
    logic [31:0] hi_in;
    logic [31:0] extracted;
    logic [3:0]  store_width;
    logic        bad_code;
    logic        illegal;

    assign bad_code    = req_funct3 == 3'd3 || req_funct3 >= 3'd6 || (req_write && req_funct3[2]);
    assign store_width = req_funct3 == F3_B ? W_B : req_funct3 == F3_H ? W_H : W_W;

`ifdef LSU_MISALIGNED_EN
    logic [29:0] base_q;
    logic        split_q;
    logic [31:0] lo_q;

    assign lo_in   = state == WAIT1 ? lo_q : mem_data_in;
    assign hi_in   = state == WAIT1 ? mem_data_in : 32'h0;
    assign illegal = bad_code || (req_write && misaligned(req_funct3, req_address[1:0]));
`else
    assign lo_in   = mem_data_in;
    assign hi_in   = 32'h0;
    assign illegal = bad_code || misaligned(req_funct3, req_address[1:0]);
`endif

    lsu_extract u_extract (
        .lo     (lo_in),
        .hi     (hi_in),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (extracted)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_error   <= 1'b0;
            mem_address  <= 32'h0;
            mem_width    <= W_NONE;
            mem_write    <= 1'b0;
            mem_data_out <= 32'h0;
            write_q      <= 1'b0;
            funct3_q     <= 3'd0;
            offset_q     <= 2'd0;
`ifdef LSU_MISALIGNED_EN
            base_q       <= 30'h0;
            split_q      <= 1'b0;
            lo_q         <= 32'h0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    write_q   <= req_write;
                    funct3_q  <= req_funct3;
                    offset_q  <= req_address[1:0];
`ifdef LSU_MISALIGNED_EN
                    base_q    <= req_address[31:2];
                    split_q   <= !req_write && needs_split(req_funct3, req_address[1:0]);
`endif
                    if (illegal) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_rdata <= ERROR_RDATA;
                    end else begin
                        state        <= ACC0;
                        mem_address  <= req_write ? req_address : {req_address[31:2], 2'b00};
                        mem_width    <= req_write ? store_width : W_W;
                        mem_write    <= req_write;
                        mem_data_out <= req_write ? req_wdata : 32'h0;
                    end
                end
                ACC0: begin
                    mem_address  <= 32'h0;
                    mem_width    <= W_NONE;
                    mem_write    <= 1'b0;
                    mem_data_out <= 32'h0;
                    state        <= write_q ? RESP : WAIT0;
                    resp_valid   <= write_q;
                end
`ifdef LSU_MISALIGNED_EN
                WAIT0: if (split_q) begin
                    lo_q        <= mem_data_in;
                    mem_address <= {base_q + 30'd1, 2'b00};
                    mem_width   <= W_W;
                    state       <= ACC1;
                end else begin
                    resp_valid <= 1'b1;
                    resp_rdata <= extracted;
                    state      <= RESP;
                end
                ACC1: begin
                    mem_address <= 32'h0;
                    mem_width   <= W_NONE;
                    state       <= WAIT1;
                end
                WAIT1: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= extracted;
                    state      <= RESP;
                end
`else
                WAIT0: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= extracted;
                    state      <= RESP;
                end
`endif
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'h0;
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed scoreboard bench for riscv_lsu with a behavioural
// synchronous-read memory; expectations follow LSU_MISALIGNED_EN.
module tb_riscv_lsu;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_address = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [3:0]  mem_width;
    logic        mem_write;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;

    typedef struct {logic [31:0] rdata; logic err; int lat;} exp_t;
    exp_t        sb[$];
    logic [31:0] rd_addrs[$];
    logic [31:0] mem[256];
    int          vectors = 0;
    int          miscompares = 0;
    logic [3:0]  c1_width;
    logic [31:0] c1_address;
    logic        c1_write;
    logic        wrote;

    riscv_lsu dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_funct3   (req_funct3),
        .req_address  (req_address),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_address  (mem_address),
        .mem_width    (mem_width),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in)
    );

    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[16]  = 32'h80F0_1234;
        mem[20]  = 32'h4433_2211;
        mem[21]  = 32'h8877_6655;
        mem[255] = 32'hDDCC_BBAA;
        mem[0]   = 32'h0000_1111;
    end

    // Byte-lane memory: writes use address[1:0], reads return the whole word next cycle.
    always @(posedge clock) begin
        if (mem_write) begin
            if (mem_width == 4'd1)
                mem[mem_address[9:2]][8*mem_address[1:0] +: 8] = mem_data_out[7:0];
            else if (mem_width == 4'd2)
                mem[mem_address[9:2]][16*mem_address[1] +: 16] = mem_data_out[15:0];
            else if (mem_width == 4'd4)
                mem[mem_address[9:2]] = mem_data_out;
        end else if (mem_width != 4'd0) begin
            mem_data_in <= mem[mem_address[9:2]];
            rd_addrs.push_back(mem_address);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] er, input logic ee, input int el);
        int   cyc;
        exp_t e;
        sb.push_back('{er, ee, el});
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = d;
        @(posedge clock); #1;
        req_valid = 1'b0;
        c1_width = mem_width; c1_address = mem_address; c1_write = mem_write;
        wrote = mem_write;
        check({tag, "_busy"}, 32'(req_ready), 32'd0);
        cyc = 1;
        while (!resp_valid && cyc < 12) begin
            @(posedge clock); #1;
            cyc++;
            wrote |= mem_write;
        end
        check({tag, "_resp"}, 32'(resp_valid), 32'd1);
        e = sb.pop_front();
        check({tag, "_rdata"}, resp_rdata, e.rdata);
        check({tag, "_error"}, 32'(resp_error), 32'(e.err));
        check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        @(posedge clock); #1;
        check({tag, "_pulse"}, {resp_valid, resp_error, req_ready}, 32'b001);
        check({tag, "_rdata_idle"}, resp_rdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        req_valid = 1'b1; req_funct3 = 3'd2; req_address = 32'h40;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_outs", {resp_valid, resp_error, mem_write, mem_width}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_maddr", mem_address, 32'h0);
        check("rst_mdata", mem_data_out, 32'h0);
        reset = 1'b0; req_valid = 1'b0;
        @(posedge clock); #1;
        check("post_rst_idle", {resp_valid, req_ready}, 32'b01);

        run_req("lb_42", 0, 3'd0, 32'h42, 0, 32'hFFFF_FFF0, 0, 3);
        run_req("lbu_43", 0, 3'd4, 32'h43, 0, 32'h0000_0080, 0, 3);
        run_req("lh_40", 0, 3'd1, 32'h40, 0, 32'h0000_1234, 0, 3);
        run_req("lhu_42", 0, 3'd5, 32'h42, 0, 32'h0000_80F0, 0, 3);
        run_req("lw_40", 0, 3'd2, 32'h40, 0, 32'h80F0_1234, 0, 3);
        run_req("lw_44_pre", 0, 3'd2, 32'h44, 0, 32'h0, 0, 3);
        run_req("sb_45", 1, 3'd0, 32'h45, 32'h0000_00AB, 32'h0, 0, 2);
        check("sb_45_c1_width", 32'(c1_width), 32'd1);
        check("sb_45_c1_addr", c1_address, 32'h45);
        check("sb_45_c1_write", 32'(c1_write), 32'd1);
        run_req("lw_44_post", 0, 3'd2, 32'h44, 0, 32'h0000_AB00, 0, 3);
        run_req("sh_46", 1, 3'd1, 32'h46, 32'h1234_5678, 32'h0, 0, 2);
        run_req("lw_44_sh", 0, 3'd2, 32'h44, 0, 32'h5678_AB00, 0, 3);

        run_req("sw_102", 1, 3'd2, 32'h102, 32'hFFFF_FFFF, 32'h0, 1, 1);
        check("sw_102_nowrite", 32'(wrote), 32'd0);
        run_req("f3_6", 0, 3'd6, 32'h40, 0, 32'h0, 1, 1);
        check("f3_6_nowrite", 32'(wrote), 32'd0);
        run_req("sbu_store", 1, 3'd4, 32'h40, 32'h11, 32'h0, 1, 1);
        check("sbu_nowrite", 32'(wrote), 32'd0);
        run_req("sh_41", 1, 3'd1, 32'h41, 32'h11, 32'h0, 1, 1);

`ifdef LSU_MISALIGNED_EN
        run_req("lw_51", 0, 3'd2, 32'h51, 0, 32'h5544_3322, 0, 5);
        run_req("lh_53", 0, 3'd1, 32'h53, 0, 32'h0000_5544, 0, 5);
        run_req("lh_41", 0, 3'd1, 32'h41, 0, 32'hFFFF_F012, 0, 3);
        rd_addrs.delete();
        run_req("lw_wrap", 0, 3'd2, 32'hFFFF_FFFE, 0, 32'h1111_DDCC, 0, 5);
        check("wrap_reads", 32'(rd_addrs.size()), 32'd2);
        if (rd_addrs.size() == 2) begin
            check("wrap_first", rd_addrs[0], 32'hFFFF_FFFC);
            check("wrap_second", rd_addrs[1], 32'h0000_0000);
        end
`else
        run_req("lw_51", 0, 3'd2, 32'h51, 0, 32'h0, 1, 1);
        run_req("lh_53", 0, 3'd1, 32'h53, 0, 32'h0, 1, 1);
        run_req("lh_41", 0, 3'd1, 32'h41, 0, 32'h0, 1, 1);
        run_req("lw_wrap", 0, 3'd2, 32'hFFFF_FFFE, 0, 32'h0, 1, 1);
`endif

        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_address = 32'h60; req_wdata = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("mid_acc0_write", 32'(mem_write), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_async_write", 32'(mem_write), 32'd0);
        check("mid_async_width", 32'(mem_width), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mid_no_resp", {resp_valid, req_ready}, 32'b01);
            @(posedge clock); #1;
        end
        run_req("lw_60_after_rst", 0, 3'd2, 32'h60, 0, 32'h0, 0, 3);
        run_req("lw_40_after_rst", 0, 3'd2, 32'h40, 0, 32'h80F0_1234, 0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the CPU32 execute stage and the data Memory port. It accepts one load or store request at a time over a valid/ready handshake and drives the synchronous-read data memory. Loads return a one-cycle response with byte/halfword extraction and sign or zero extension. Misaligned accesses are either flagged as errors or split into two aligned word reads.

## Interface
- ERROR_RDATA, 32'h0: value driven on resp_rdata when resp_error=1
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; all state to reset values immediately
- req_valid  in  1  request present
- req_ready  out  1  LSU idle, request accepted on posedge when req_valid & req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 0 b, 1 h, 2 w, 4 bu, 5 hu (4/5 load only)
- req_address  in  32  byte address (rs1 + offset, computed by CPU)
- req_wdata  in  32  store data, value in low bits
- resp_valid  out  1  one-cycle response pulse, no backpressure
- resp_rdata  out  32  extended load data; 0 for stores
- resp_error  out  1  misaligned or illegal request, no memory access made
- mem_address  out  32  to Memory address
- mem_width  out  4  1/2/4 bytes, 0 = no access
- mem_write  out  1  Memory write enable
- mem_data_out  out  32  Memory write data
- mem_data_in  in  32  Memory read data, valid the cycle after the access cycle

## Operation
- States: IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP (ACC1/WAIT1 only with macro).
- IDLE: req_ready=1; mem_* all 0. On accept, register request, compute legality; legal -> ACC0, illegal -> RESP with error.
- Illegal: funct3 3/6/7; funct3 4/5 with req_write=1; misaligned store (sh at a[0]=1, sw at a[1:0]!=0); misaligned load when macro is off.
- Load ACC0: mem_address = addr & ~3, mem_width=4, mem_write=0. -> WAIT0.
- WAIT0: mem_width=0; capture mem_data_in as lo. Aligned -> RESP; split -> ACC1.
- ACC1: mem_address = (addr & ~3) + 4 (mod 2^32), mem_width=4. -> WAIT1: capture hi -> RESP.
- Extraction: word = ({hi,lo} >> 8*addr[1:0])[31:0] (hi=0 unsplit); lb/lh sign-extend bit 7/15, lbu/lhu zero-extend.
- Store ACC0: mem_address = addr, mem_width = 1/2/4 per funct3, mem_write=1, mem_data_out = req_wdata unshifted (Memory selects lane by address[1:0]). -> RESP.
- RESP: resp_valid=1 for exactly one cycle, registered data/error; -> IDLE.
- Outputs registered from state and captured request only; no combinational path req_* -> mem_*.

## Timing
- Acceptance edge = T0. Aligned load: ACC0 cycle 1, WAIT0 cycle 2, resp_valid cycle 3. Split load: resp_valid cycle 5. Store: ACC0 cycle 1, resp_valid cycle 2. Illegal: resp_valid cycle 1.
- req_ready low from the cycle after T0 through RESP; next accept earliest at the edge ending the first IDLE cycle.
- Requests presented while reset is high are ignored.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_address=0, mem_width=0, mem_write=0, mem_data_out=0, state IDLE.
- Reset mid-operation: in-flight access abandoned, mem_write drops asynchronously, no response issued.
- resp_rdata/resp_error hold their value only during resp_valid; 0 otherwise.

## Configuration
- LSU_MISALIGNED_EN defined: misaligned loads (lw a[1:0]!=0; lh/lhu a[1:0]==3) split into two word reads via ACC1/WAIT1. lh/lhu at a[1:0]==1 stays single-read. Misaligned stores remain errors.
- Undefined: ACC1/WAIT1 not built; every misaligned load is an error response (ERROR_RDATA, resp_error=1).

## Structure
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, mem width codes (W_NONE=0, W_B=1, W_H=2, W_W=4).
- Sub-module lsu_extract: combinational {hi,lo}, addr[1:0], funct3 -> 32-bit extended result; instantiated once.

## Test plan
- Word at 0x40 = 0x80F0_1234; lb 0x42 -> resp_rdata 0xFFFF_FFF0; lbu 0x43 -> 0x0000_0080; lh 0x40 -> 0x0000_1234; each resp_valid 3 cycles after accept.
- sb 0x45 wdata 0xAB: cycle 1 mem_width=1, mem_address=0x45, mem_write=1; resp_valid cycle 2; subsequent lw 0x44 shows 0x0000_AB00 (prior 0).
- sw 0x102 -> resp_error=1, resp_rdata=ERROR_RDATA, resp_valid cycle 1, mem_write never asserted; same for req_funct3=6 load.
- Macro on: words 0x50=0x4433_2211, 0x54=0x8877_6655; lw 0x51 -> 0x5544_3322 at cycle 5; lh 0x53 -> 0x0000_5544. Macro off: same lw -> error cycle 1.
- lw at 0xFFFF_FFFE with macro: second read address 0x0000_0000 (wrap).
- Assert reset during ACC0 of a store: mem_write falls without a clock edge, no resp_valid, req_ready=1 after release; next load completes normally.
